// File: rtl/gsim_rd_sched.sv
// gsim_rd_sched: matrix-memory read scheduler and beat tagger for the GSIM Gauss-Seidel datapath.
// Define GSIM_SCHED_PERF_EN to add the saturating stall-cycle counter on o_perf_stall.
module gsim_rd_sched #(
  parameter int ITERS     = 16,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_module_en,
  input  logic [4:0]        i_matrix_num,
  output logic              o_proc_done,
  output logic              o_mem_rreq,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic              i_mem_dout_vld,
  input  logic [255:0]      i_mem_dout,
  input  logic              i_dp_stall,
  input  logic              i_dp_mat_done,
  output logic              o_beat_vld,
  output logic [255:0]      o_beat_data,
  output logic              o_beat_phase,
  output logic [3:0]        o_beat_iter,
  output logic [4:0]        o_beat_col,
  output logic              o_beat_last,
  output logic [4:0]        o_mat_idx,
  output logic              o_err
`ifdef GSIM_SCHED_PERF_EN
  ,
  output logic [15:0]       o_perf_stall
`endif
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int FD    = 1 << PTR_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_DRAIN, S_DONE} state_e;
  typedef struct packed {
    logic       phase;
    logic [3:0] iter;
    logic [4:0] col;
  } tag_t;

  state_e            state_q, state_d;
  logic [4:0]        mat_idx_q, mat_idx_d, mat_num_q, mat_num_d, col_q, col_d;
  logic [3:0]        iter_q, iter_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              rreq_q, rreq_d, done_q, done_d, seen_q, seen_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tag_t              fifo_q [FD];
  tag_t              push_tag, head;
  logic              accept, pop, fifo_empty, remain, hold;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept     = rreq_q & i_mem_rrdy;
  assign fifo_empty = (cnt_q == 4'd0);
  assign pop        = i_mem_dout_vld & ~fifo_empty;
  assign hold       = rreq_q & ~i_mem_rrdy;
  assign head       = fifo_q[rd_ptr_q];
  assign push_tag   = '{phase: (state_q == S_ITER), iter: iter_q, col: col_q};

  always_comb begin
    // NOTE: every signal gets its default before the case so no path can infer a latch.
    state_d   = state_q;
    mat_idx_d = mat_idx_q;
    mat_num_d = mat_num_q;
    col_d     = col_q;
    iter_d    = iter_q;
    seen_d    = seen_q | i_dp_mat_done;
    err_d     = err_q | (i_mem_dout_vld & fifo_empty);
    cnt_d     = cnt_q + {3'b000, accept} - {3'b000, pop};
    wr_ptr_d  = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        seen_d = 1'b0;
        if (i_module_en) begin
          mat_num_d = i_matrix_num;
          mat_idx_d = '0;
          col_d     = '0;
          iter_d    = '0;
          state_d   = (i_matrix_num == 5'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: if (accept) begin
        if (col_q == 5'd16) begin
          state_d = S_ITER;
          col_d   = '0;
          iter_d  = '0;
        end else col_d = col_q + 5'd1;
      end
      S_ITER: if (accept) begin
        if (col_q == 5'd15) begin
          col_d = '0;
          if (iter_q == 4'(ITERS - 1)) state_d = S_DRAIN;
          else                         iter_d  = iter_q + 4'd1;
        end else col_d = col_q + 5'd1;
      end
      S_DRAIN: if ((cnt_q == 4'd0) && (seen_q || i_dp_mat_done)) begin
        seen_d = 1'b0;
        col_d  = '0;
        iter_d = '0;
        if (mat_idx_q == mat_num_q - 5'd1) state_d = S_DONE;
        else begin
          mat_idx_d = mat_idx_q + 5'd1;
          state_d   = S_LOAD;
        end
      end
      S_DONE: begin
        seen_d = 1'b0;
        if (!i_module_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE) & i_module_en;

    // An unaccepted request is held as-is; otherwise raise the next one if the phase still has work.
    remain = (state_d == S_LOAD) || (state_d == S_ITER);
    rreq_d = 1'b0;
    addr_d = addr_q;
    if (hold) rreq_d = 1'b1;
    else if (remain && !i_dp_stall && (cnt_d < 4'(MAX_OUTST))) begin
      rreq_d = 1'b1;
      addr_d = ADDR_W'({mat_idx_d, 4'b0000}) + ADDR_W'(mat_idx_d) + ADDR_W'(col_d);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      mat_idx_q <= '0;
      mat_num_q <= '0;
      col_q     <= '0;
      iter_q    <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rreq_q    <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      // NOTE: the tag store is only a few flops, so it is cleared too and the tag outputs read 0 after reset.
      for (int i = 0; i < FD; i++) fifo_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      mat_idx_q <= mat_idx_d;
      mat_num_q <= mat_num_d;
      col_q     <= col_d;
      iter_q    <= iter_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rreq_q    <= rreq_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      if (accept) fifo_q[wr_ptr_q] <= push_tag;
    end
  end

  assign o_proc_done  = done_q;
  assign o_mem_rreq   = rreq_q;
  assign o_mem_addr   = addr_q;
  assign o_beat_vld   = pop;
  assign o_beat_data  = i_mem_dout;
  assign o_beat_phase = head.phase;
  assign o_beat_iter  = head.iter;
  assign o_beat_col   = head.col;
  assign o_beat_last  = pop & head.phase & (head.iter == 4'(ITERS - 1)) & (head.col == 5'd15);
  assign o_mat_idx    = mat_idx_q;
  assign o_err        = err_q;

`ifdef GSIM_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;
  logic        stall_evt;

  // Counts both a presented-but-refused request and a wanted request held back by stall or credit.
  always_comb begin
    stall_evt = hold | (remain & ~rreq_d);
    perf_d    = perf_q;
    if ((state_q == S_IDLE) && (state_d == S_LOAD)) perf_d = '0;
    else if (stall_evt && (perf_q != 16'hFFFF))     perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign o_perf_stall = perf_q;
`endif

endmodule

// File: doc/gsim_rd_sched.md
Name: gsim_rd_sched

Overview:
Read scheduler and sequencer for the GSIM Gauss-Seidel datapath. It generates the matrix-memory address stream for each problem: a 17-row load phase, then ITERS iteration sweeps of 16 columns. It runs the memory request handshake with a bounded number of outstanding reads. It tags every returned beat with phase, iteration and column so the arithmetic datapath needs no counters of its own.

Parameters:
ITERS, 16, iteration sweeps per matrix (1..16)
MAX_OUTST, 4, maximum accepted-but-unreturned reads (1..8); also the tag FIFO depth
ADDR_W, 10, memory address width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_module_en  in  1  start; level, sampled in IDLE; must stay high until o_proc_done
i_matrix_num  in  5  number of problems; 0..31 valid
o_proc_done  out  1  high in DONE while i_module_en is high
o_mem_rreq  out  1  read request, registered
o_mem_addr  out  ADDR_W  read address, registered, valid with o_mem_rreq
i_mem_rrdy  in  1  memory accepts the request this cycle
i_mem_dout_vld  in  1  read data beat returned, in request order
i_mem_dout  in  256  read data
i_dp_stall  in  1  datapath asks to hold off new requests
i_dp_mat_done  in  1  one-cycle pulse: datapath has written back x for the current matrix
o_beat_vld  out  1  i_mem_dout_vld gated by tag FIFO not empty (combinational)
o_beat_data  out  256  i_mem_dout pass-through
o_beat_phase  out  1  0 = LOAD, 1 = ITER
o_beat_iter  out  4  iteration index of the beat
o_beat_col  out  5  column/row index (0..16)
o_beat_last  out  1  last beat of the current matrix
o_mat_idx  out  5  current matrix index
o_err  out  1  sticky: data returned while no read was outstanding

Behaviour:
- Single clock i_clk. Reset i_reset is synchronous and active-high; all registers clear on the reset edge.
- Reset values: all outputs 0, FSM in IDLE, all counters 0, tag FIFO empty.
- A request is accepted when o_mem_rreq && i_mem_rrdy in the same cycle.
- o_mem_rreq/o_mem_addr hold stable until accepted; no retraction, including when i_dp_stall rises.
- After an acceptance, the next request may be presented in the following cycle, so a back-to-back stream reaches 1 request per cycle.
- outst = accepted minus returned. On accept, outst +1 and the tag is pushed. On o_beat_vld, outst -1 and the tag is popped. Accept and return in the same cycle: outst unchanged, FIFO push and pop both occur.
- A new request is raised (next-cycle o_mem_rreq=1) only when all of these hold: requests remain in the phase, i_dp_stall=0, and outst_next < MAX_OUTST.
- Address = 17*mat_idx + col (max 17*30+16 = 526, fits 10 bits); mat_idx is unsigned and wraps never.
- FSM:
  IDLE: i_module_en=1 goes to LOAD with mat_idx=0, or to DONE if i_matrix_num=0.
  LOAD: issue cols 0..16 (17 requests). After the col-16 acceptance, go to ITER with iter=0, col=0.
  ITER: issue cols 0..15 per iter. After the col-15 acceptance of iter ITERS-1, go to DRAIN.
  DRAIN: no requests. Wait for outst=0 and an i_dp_mat_done pulse; a pulse seen earlier in the matrix (in any state) is remembered.
  Leaving DRAIN: if mat_idx = i_matrix_num-1, go to DONE; else mat_idx +1 and go to LOAD.
  DONE: o_proc_done = i_module_en. i_module_en=0 goes to IDLE.
- i_module_en dropping before DONE is ignored; only reset aborts.
- Beat tags come from the FIFO head with zero latency. o_beat_last=1 on the ITER beat with iter=ITERS-1, col=15.
- i_mem_dout_vld with the FIFO empty: o_beat_vld=0, o_err is set and holds until reset. This covers late data after a mid-operation reset; those beats are dropped.
- i_matrix_num is sampled in IDLE; changes after leaving IDLE are ignored.

Optional Feature:
GSIM_SCHED_PERF_EN
- Defined: adds output o_perf_stall 16-bit, saturating at 0xFFFF. It counts cycles where o_mem_rreq=1 && i_mem_rrdy=0, plus cycles where a request is blocked by outst or i_dp_stall. Cleared on reset and on the IDLE to LOAD transition.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- i_matrix_num=1, i_mem_rrdy=1, 2-cycle fixed read latency, ITERS=16 -> exactly 17+256=273 requests; addresses 0..16, then 0..15 repeated 16 times; one o_beat_last; o_proc_done rises after the i_dp_mat_done pulse.
- i_matrix_num=3 -> LOAD addresses start at 0, 17, 34; o_mat_idx steps 0,1,2; the final address is 49; o_proc_done drops 1 cycle after i_module_en=0 and the FSM re-enters IDLE.
- Memory read latency 10 cycles, MAX_OUTST=4 -> never more than 4 outstanding; o_mem_rreq deasserts at outst=4 and reasserts the cycle after a return.
- i_mem_rrdy toggled randomly and i_dp_stall pulsed -> o_mem_addr is stable while unaccepted; tags match the issue order with no loss or duplication.
- Reset asserted mid-ITER with 3 reads outstanding, followed by 3 late i_mem_dout_vld -> outputs are at reset values, o_beat_vld=0, and o_err=1.
- i_matrix_num=0 -> DONE one cycle after i_module_en, with zero requests issued.
